lc3b_fetch_unit: RTL
====================

// Module: lc3b_fetch_unit
// PURPOSE
//  Instruction-fetch front end of the LC-3b datapath; owns the architectural PC.
//  - Fetches 16-bit instructions from memory over the mem_read/mem_resp handshake.
//  - Hands each instruction to decode with a valid/ready handshake.
//  - Accepts PC redirects from the branch target adder (PC+2+SEXT(off<<1)) and discards wrong-path fetches.
// PARAMETERS
//  RESET_PC  16'h0000  PC loaded on reset; bit 0 must be 0
// PORTS
//  clk           in   1   clock; all state updates on rising edge
//  reset         in   1   asynchronous, active-high reset
//  redirect      in   1   one-cycle pulse: load PC from redirect_pc
//  redirect_pc   in   16  branch/jump target (lc3b_word)
//  mem_read      out  1   fetch request; held high until mem_resp
//  mem_address   out  16  fetch address; stable while mem_read=1
//  mem_resp      in   1   memory completes the current read this cycle
//  mem_rdata     in   16  instruction word, valid when mem_resp=1
//  ir_valid      out  1   ir_out/ir_pc/ir_npc hold a valid instruction
//  ir_ready      in   1   decode accepts the instruction this cycle
//  ir_out        out  16  instruction word
//  ir_pc         out  16  address of ir_out
//  ir_npc        out  16  ir_pc+2, feeds the branch target adder
// BEHAVIOUR
//  Reset: state=START, pc=RESET_PC, fetch_addr=RESET_PC; mem_read=0, ir_valid=0, ir_out/ir_pc/ir_npc=0.
//  States:
//   START   : single idle cycle after reset; next=FETCH.
//             If redirect is asserted, pc <= redirect_pc first.
//   FETCH   : mem_read=1, mem_address=fetch_addr.
//             mem_resp & !redirect : latch ir_out=mem_rdata, ir_pc=fetch_addr, ir_npc=fetch_addr+2; next=HOLD.
//             mem_resp & redirect  : drop data; pc=fetch_addr=redirect_pc; next=FETCH (new request next cycle).
//             !mem_resp & redirect : pending_pc=redirect_pc; next=DISCARD.
//   DISCARD : mem_read=1, mem_address unchanged (old fetch_addr).
//             Another redirect overwrites pending_pc (last one wins).
//             On mem_resp: drop data; fetch_addr=pc=pending_pc; next=FETCH.
//   HOLD    : ir_valid=1.
//             redirect (priority over ir_ready): the handshake is void; ir_valid=0 next cycle;
//               pc=fetch_addr=redirect_pc; next=FETCH.
//             ir_ready & !redirect: fetch_addr=pc=ir_pc+2; next=FETCH.
//             Otherwise hold all ir_* stable.
//  Latency: ir_valid rises the cycle after mem_resp. Back-to-back throughput is 1 instruction per (mem latency + 2) cycles.
//  Arithmetic: 16-bit unsigned with wrap; 16'hFFFE+2 = 16'h0000. redirect_pc[0] is forced to 0.
//  mem_read is a decode of state; it never drops before mem_resp (no request abort).
//  Asynchronous reset mid-transaction returns to START immediately; the late mem_resp is ignored because START does not sample it.
//  mem_resp outside FETCH/DISCARD is ignored.
// STRUCTURE
//  lc3b_types package additions:
//   - lc3b_fetch_state enum {START, FETCH, DISCARD, HOLD}
//   - constant LC3B_RESET_PC
//  One sub-module: lc3b_plus2 (lc3b_word in -> in+2), shared by ir_npc and the next-fetch address.
//  Registers: state, pc, fetch_addr, pending_pc, ir_out, ir_pc, ir_npc.
// TESTING
//  1. Reset, then a 1-cycle-latency memory returning 16'h1234 at 0x0000:
//     mem_read at cycle 1; ir_valid=1, ir_out=16'h1234, ir_npc=0x0002 the cycle after resp.
//  2. ir_ready held low for 5 cycles in HOLD: ir_* stable, mem_read=0.
//     ir_ready=1: next request at 0x0002.
//  3. redirect to 0x3000 during a 4-cycle fetch of 0x0004:
//     mem_address stays 0x0004 until resp; data dropped; next request at 0x3000; ir_valid never 1 for 0x0004.
//  4. redirect to 0x4000 and ir_ready together in HOLD: ir_valid=0 next cycle; next request at 0x4000.
//  5. Two redirects (0x5000 then 0x6000) in DISCARD: next request at 0x6000.
//     redirect_pc=0x7001: request at 0x7000.
//  6. PC 0xFFFE consumed: next request at 0x0000.
//     reset asserted mid-fetch: mem_read=0 immediately; restart at RESET_PC.

Source files
------------

// File: rtl/lc3b_fetch_unit_pkg.sv
// Shared types and constants for the LC-3b instruction-fetch front end.
package lc3b_fetch_unit_pkg;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    START,
    FETCH,
    DISCARD,
    HOLD
  } lc3b_fetch_state;

  localparam lc3b_word LC3B_RESET_PC = 16'h0000;

  // Instructions are halfword aligned, so a target's low bit carries no meaning.
  function automatic lc3b_word align_pc(input lc3b_word word);
    return {word[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/lc3b_fetch_unit_plus2.sv
// Sequential-PC incrementer (word + 2, wrapping at 16 bits).
module lc3b_plus2
  import lc3b_fetch_unit_pkg::*;
(
  input  lc3b_word word,
  output lc3b_word sum
);

  assign sum = word + 16'd2;

endmodule

// File: rtl/lc3b_fetch_unit.sv
// LC-3b fetch front end: owns the PC, fetches over mem_read/mem_resp and
// presents instructions to decode, dropping wrong-path fetches on redirect.
module lc3b_fetch_unit
  import lc3b_fetch_unit_pkg::*;
#(
  parameter lc3b_word RESET_PC = LC3B_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        mem_read,
  output logic [15:0] mem_address,
  input  logic        mem_resp,
  input  logic [15:0] mem_rdata,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [15:0] ir_out,
  output logic [15:0] ir_pc,
  output logic [15:0] ir_npc
);

  lc3b_fetch_state state, state_d;
  lc3b_word        pc, pc_d;
  lc3b_word        fetch_addr, fetch_addr_d;
  lc3b_word        pending_pc, pending_pc_d;
  lc3b_word        next_addr;
  lc3b_word        target;
  logic            ir_load;

  // fetch_addr equals ir_pc while in HOLD, so one incrementer serves both
  // ir_npc and the sequential next-fetch address.
  lc3b_plus2 u_plus2 (
    .word (fetch_addr),
    .sum  (next_addr)
  );

  assign target      = align_pc(redirect_pc);
  assign mem_read    = (state == FETCH) || (state == DISCARD);
  assign mem_address = fetch_addr;
  assign ir_valid    = (state == HOLD);

  always_comb begin
    state_d      = state;
    pc_d         = pc;
    fetch_addr_d = fetch_addr;
    pending_pc_d = pending_pc;
    ir_load      = 1'b0;
    case (state)
      START: begin
        state_d = FETCH;
        if (redirect) begin
          pc_d         = target;
          fetch_addr_d = target;
        end
      end
      FETCH: begin
        if (mem_resp) begin
          if (redirect) begin
            pc_d         = target;
            fetch_addr_d = target;
          end else begin
            ir_load = 1'b1;
            state_d = HOLD;
          end
        end else if (redirect) begin
          pending_pc_d = target;
          state_d      = DISCARD;
        end
      end
      DISCARD: begin
        // A redirect arriving with the response is the newest target.
        if (mem_resp) begin
          pc_d         = redirect ? target : pending_pc;
          fetch_addr_d = redirect ? target : pending_pc;
          state_d      = FETCH;
        end else if (redirect) begin
          pending_pc_d = target;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d         = target;
          fetch_addr_d = target;
          state_d      = FETCH;
        end else if (ir_ready) begin
          pc_d         = next_addr;
          fetch_addr_d = next_addr;
          state_d      = FETCH;
        end
      end
      default: state_d = START;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= START;
      pc         <= RESET_PC;
      fetch_addr <= RESET_PC;
      pending_pc <= RESET_PC;
      ir_out     <= '0;
      ir_pc      <= '0;
      ir_npc     <= '0;
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      fetch_addr <= fetch_addr_d;
      pending_pc <= pending_pc_d;
      if (ir_load) begin
        ir_out <= mem_rdata;
        ir_pc  <= fetch_addr;
        ir_npc <= next_addr;
      end
    end
  end

endmodule
